// File: rtl/dinogame_input_ctrl.sv
// rtl/dinogame_input_ctrl.sv - switch synchronise/debounce, jump pulse, debug toggle, frame-latched config
module dinogame_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int DEFAULT_ACCEL   = 4,
    parameter int DEFAULT_SPEED   = 2
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       jump_raw,
    input  logic       halt_raw,
    input  logic       debug_raw,
    input  logic       cfg_override,
    input  logic [7:0] cfg_in,
    input  logic       frame_start,
    output logic       jump_level,
    output logic       jump_press,
    output logic       halt_level,
    output logic       debug_mode,
    output logic [3:0] cfg_accel,
    output logic [3:0] cfg_speed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] ACCEL_RST = 4'(DEFAULT_ACCEL);
    localparam logic [3:0] SPEED_RST = 4'(DEFAULT_SPEED);
    localparam int JUMP  = 0;
    localparam int HALT  = 1;
    localparam int DEBUG = 2;

    logic [2:0]    sw_meta;
    logic [2:0]    sw_sync;
    logic [2:0]    stable;
    logic [2:0]    accept;
    logic [CW-1:0] cnt [3];
    logic          ovr_meta;
    logic          ovr_sync;
    logic [7:0]    cfg_meta;
    logic [7:0]    cfg_sync;
    logic          jump_press_q;
    logic          debug_mode_q;
    logic [3:0]    accel_q;
    logic [3:0]    speed_q;

    // A channel accepts its new level on the edge its counter has already reached the limit.
    always_comb begin
        accept = '0;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (sw_sync[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            sw_meta      <= '0;
            sw_sync      <= '0;
            stable       <= '0;
            ovr_meta     <= 1'b0;
            ovr_sync     <= 1'b0;
            cfg_meta     <= '0;
            cfg_sync     <= '0;
            jump_press_q <= 1'b0;
            debug_mode_q <= 1'b0;
            accel_q      <= ACCEL_RST;
            speed_q      <= SPEED_RST;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sw_meta  <= {debug_raw, halt_raw, jump_raw};
            sw_sync  <= sw_meta;
            ovr_meta <= cfg_override;
            ovr_sync <= ovr_meta;
            cfg_meta <= cfg_in;
            cfg_sync <= cfg_meta;
            for (int i = 0; i < 3; i++) begin
                if (sw_sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sw_sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            jump_press_q <= accept[JUMP] & sw_sync[JUMP];
            if (accept[DEBUG] && sw_sync[DEBUG]) begin
                debug_mode_q <= ~debug_mode_q;
            end
            // Config only moves at frame boundaries, using the pre-edge synchronised value.
            if (frame_start) begin
                if (ovr_sync) begin
                    accel_q <= cfg_sync[7:4];
                    speed_q <= cfg_sync[3:0];
                end else begin
                    accel_q <= ACCEL_RST;
                    speed_q <= SPEED_RST;
                end
            end
        end
    end

    assign jump_level = stable[JUMP];
    assign halt_level = stable[HALT];
    assign jump_press = jump_press_q;
    assign debug_mode = debug_mode_q;
    assign cfg_accel  = accel_q;
    assign cfg_speed  = speed_q;

endmodule
